// File: rtl/fft_frame_sched_pkg.sv
// rtl/fft_frame_sched_pkg.sv - shared FFT constants, FSM encodings and helpers; FFT_SCHED_BITREV_EN selects bit-reversed core feed
`ifndef FFT_INC_H
`define FFT_INC_H
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 4
`endif
`ifndef REAL_WIDTH
`define REAL_WIDTH 16
`endif
`ifndef IMGN_WIDTH
`define IMGN_WIDTH 16
`endif
`define FFT_N (1 << `TOTAL_STAGE)
`define FFT_ST_IDLE 1'b0
`define FFT_ST_STREAM 1'b1
`endif

package fft_frame_sched_pkg;
  localparam int TOTAL_STAGE = `TOTAL_STAGE;
  localparam int N = `FFT_N;

  typedef logic [TOTAL_STAGE-1:0] addr_t;
  localparam addr_t ADDR_LAST = addr_t'(N - 1);

  typedef enum logic {
    ST_IDLE   = `FFT_ST_IDLE,
    ST_STREAM = `FFT_ST_STREAM
  } state_e;

`ifdef FFT_SCHED_BITREV_EN
  function automatic addr_t bit_rev(addr_t a);
    addr_t r;
    r = '0;
    for (int i = 0; i < TOTAL_STAGE; i++) r[i] = a[TOTAL_STAGE-1-i];
    return r;
  endfunction
`endif
endpackage

// File: rtl/fft_frame_sched_if.sv
// rtl/fft_frame_sched_if.sv - source, core and result signal bundle for fft_frame_sched
interface fft_frame_sched_if;
  logic                    s0_valid, s1_valid;
  logic                    s0_ready, s1_ready;
  logic [`REAL_WIDTH-1:0]  s0_real, s1_real;
  logic [`IMGN_WIDTH-1:0]  s0_imag, s1_imag;

  logic                    c_en;
  logic [`TOTAL_STAGE-1:0] c_addr;
  logic [`REAL_WIDTH-1:0]  c_real;
  logic [`IMGN_WIDTH-1:0]  c_imag;

  logic                    r_en;
  logic [`TOTAL_STAGE-1:0] r_addr;
  logic [`REAL_WIDTH-1:0]  r_real;
  logic [`IMGN_WIDTH-1:0]  r_imag;

  logic                    oen;
  logic [`TOTAL_STAGE-1:0] oaddr;
  logic [`REAL_WIDTH-1:0]  oReal;
  logic [`IMGN_WIDTH-1:0]  oImag;
  logic                    ochan, olast, busy, err;

  modport slave (
    input  s0_valid, s1_valid, s0_real, s1_real, s0_imag, s1_imag,
    input  r_en, r_addr, r_real, r_imag,
    output s0_ready, s1_ready, c_en, c_addr, c_real, c_imag,
    output oen, oaddr, oReal, oImag, ochan, olast, busy, err
  );

  modport master (
    output s0_valid, s1_valid, s0_real, s1_real, s0_imag, s1_imag,
    output r_en, r_addr, r_real, r_imag,
    input  s0_ready, s1_ready, c_en, c_addr, c_real, c_imag,
    input  oen, oaddr, oReal, oImag, ochan, olast, busy, err
  );
endinterface

// File: rtl/fft_tag_fifo.sv
// rtl/fft_tag_fifo.sv - 1-bit channel tag FIFO for frames in flight inside the core
module fft_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = empty_o ? 1'b0 : mem_q[rd_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - round-robin frame scheduler sharing one FFT core between two sources
// FFT_SCHED_BITREV_EN: feed the core in bit-reversed address order.
module fft_frame_sched
  import fft_frame_sched_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input logic              iclk,
  input logic              rst_n,
  fft_frame_sched_if.slave bus
);
  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   rr_q, rr_d;
  addr_t  cnt_q, cnt_d;

  logic                   c_en_q;
  addr_t                  c_addr_q;
  logic [`REAL_WIDTH-1:0] c_real_q;
  logic [`IMGN_WIDTH-1:0] c_imag_q;

  addr_t                  ocnt_q;
  logic                   oen_q, olast_q, ochan_q, err_q;
  addr_t                  oaddr_q;
  logic [`REAL_WIDTH-1:0] oreal_q;
  logic [`IMGN_WIDTH-1:0] oimag_q;

  logic                   sel_valid, accept, push, pop, r_last;
  logic                   fifo_full, fifo_empty, fifo_head;
  logic [`REAL_WIDTH-1:0] sel_real;
  logic [`IMGN_WIDTH-1:0] sel_imag;
  addr_t                  feed_addr;

  assign sel_valid = gnt_q ? bus.s1_valid : bus.s0_valid;
  assign sel_real  = gnt_q ? bus.s1_real  : bus.s0_real;
  assign sel_imag  = gnt_q ? bus.s1_imag  : bus.s0_imag;
  assign accept    = (state_q == ST_STREAM) && sel_valid;

`ifdef FFT_SCHED_BITREV_EN
  assign feed_addr = bit_rev(cnt_q);
`else
  assign feed_addr = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The full check here is what keeps pushes from ever hitting a full FIFO.
        if (!fifo_full && (bus.s0_valid || bus.s1_valid)) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
          gnt_d   = (rr_q ? bus.s1_valid : bus.s0_valid) ? rr_q : ~rr_q;
        end
      end
      ST_STREAM: begin
        if (sel_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            push    = 1'b1;
            rr_d    = ~gnt_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result frames are delimited purely by counting r_en, whatever order the core emits addresses in.
  assign r_last = (ocnt_q == ADDR_LAST);
  assign pop    = bus.r_en && r_last && !fifo_empty;

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      c_en_q   <= 1'b0;
      c_addr_q <= '0;
      c_real_q <= '0;
      c_imag_q <= '0;
      ocnt_q   <= '0;
      oen_q    <= 1'b0;
      olast_q  <= 1'b0;
      ochan_q  <= 1'b0;
      oaddr_q  <= '0;
      oreal_q  <= '0;
      oimag_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      c_en_q  <= accept;
      if (accept) begin
        c_addr_q <= feed_addr;
        c_real_q <= sel_real;
        c_imag_q <= sel_imag;
      end
      oen_q   <= bus.r_en;
      olast_q <= bus.r_en && r_last;
      if (bus.r_en) begin
        ocnt_q  <= ocnt_q + 1'b1;
        oaddr_q <= bus.r_addr;
        oreal_q <= bus.r_real;
        oimag_q <= bus.r_imag;
        ochan_q <= fifo_head;
      end
      if (bus.r_en && fifo_empty) err_q <= 1'b1;
    end
  end

  fft_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i      (iclk),
    .rst_ni     (rst_n),
    .push_i     (push),
    .push_data_i(gnt_q),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  assign bus.s0_ready = (state_q == ST_STREAM) && !gnt_q;
  assign bus.s1_ready = (state_q == ST_STREAM) &&  gnt_q;
  assign bus.c_en     = c_en_q;
  assign bus.c_addr   = c_addr_q;
  assign bus.c_real   = c_real_q;
  assign bus.c_imag   = c_imag_q;
  assign bus.oen      = oen_q;
  assign bus.oaddr    = oaddr_q;
  assign bus.oReal    = oreal_q;
  assign bus.oImag    = oimag_q;
  assign bus.ochan    = ochan_q;
  assign bus.olast    = olast_q;
  assign bus.busy     = (state_q == ST_STREAM) || !fifo_empty;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - randomized self-checking bench for fft_frame_sched against a frame-level model
module tb_fft_frame_sched;
  localparam int TS = `TOTAL_STAGE;
  localparam int RW = `REAL_WIDTH;
  localparam int IW = `IMGN_WIDTH;
  localparam int NN = 1 << TS;
  localparam int DW = RW + IW;

  logic iclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 iclk = ~iclk;

  fft_frame_sched_if bus();

  fft_frame_sched #(.TAG_DEPTH(4)) dut (
    .iclk (iclk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [DW-1:0]      src0[$], src1[$], ref0[$], ref1[$];
  logic [TS+DW-1:0]   exp_o[$], cap_c[$];
  logic [TS+DW+1:0]   cap_o[$];
  int                 cap_cyc[$];
  int                 order[$];
  int                 r_left, rpct;
  bit                 alt0, hold_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [TS-1:0] addr_of(input int k);
    int r;
    r = 0;
`ifdef FFT_SCHED_BITREV_EN
    for (int b = 0; b < TS; b++) r += ((k >> b) & 1) << (TS - 1 - b);
`else
    r = k;
`endif
    return TS'(r);
  endfunction

  task automatic cycle();
    logic [DW-1:0] d;
    logic v;
    @(negedge iclk);
    cyc++;
    if (bus.c_en === 1'b1) begin
      cap_c.push_back({bus.c_addr, bus.c_real, bus.c_imag});
      cap_cyc.push_back(cyc);
    end else if (hold_chk && (cap_c.size() % NN) != 0) begin
      check("c_addr_hold", 64'(bus.c_addr), 64'(addr_of((cap_c.size() - 1) % NN)));
    end
    if (bus.oen === 1'b1) cap_o.push_back({bus.ochan, bus.olast, bus.oaddr, bus.oReal, bus.oImag});

    v = (src0.size() > 0) && (alt0 ? ((cyc % 2) == 1) : 1'b1);
    d = v ? src0[0] : DW'($urandom);
    bus.s0_valid = v;
    {bus.s0_real, bus.s0_imag} = d;
    v = (src1.size() > 0);
    d = v ? src1[0] : DW'($urandom);
    bus.s1_valid = v;
    {bus.s1_real, bus.s1_imag} = d;

    if (r_left > 0 && $urandom_range(99) < rpct) begin
      bus.r_en   = 1'b1;
      bus.r_addr = TS'($urandom);
      d = DW'($urandom);
      {bus.r_real, bus.r_imag} = d;
      exp_o.push_back({bus.r_addr, d});
      r_left--;
    end else begin
      bus.r_en = 1'b0;
    end
    #1;
    if (bus.s0_valid && bus.s0_ready) d = src0.pop_front();
    if (bus.s1_valid && bus.s1_ready) d = src1.pop_front();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_c(input int target, input int budget);
    int k = 0;
    while (cap_c.size() < target && k < budget) begin cycle(); k++; end
    check("c_wait", 64'(cap_c.size()), 64'(target));
  endtask

  task automatic run_o(input int target, input int budget);
    int k = 0;
    while (cap_o.size() < target && k < budget) begin cycle(); k++; end
    check("o_wait", 64'(cap_o.size()), 64'(target));
  endtask

  task automatic load(input int ch, input int frames);
    logic [DW-1:0] d;
    for (int i = 0; i < frames * NN; i++) begin
      d = DW'($urandom);
      if (ch == 0) begin src0.push_back(d); ref0.push_back(d); end
      else         begin src1.push_back(d); ref1.push_back(d); end
    end
  endtask

  // Grant order when both sources hold their frames ready: pointer-preferred round robin from channel 0.
  task automatic model_order(input int n0, input int n1);
    int p, c;
    p = 0;
    order.delete();
    while (n0 + n1 > 0) begin
      c = ((p == 0) ? (n0 > 0) : (n1 > 0)) ? p : 1 - p;
      order.push_back(c);
      if (c == 0) n0--; else n1--;
      p = 1 - c;
    end
  endtask

  task automatic check_c();
    logic [DW-1:0] d;
    int idx = 0;
    check("c_count", 64'(cap_c.size()), 64'(order.size() * NN));
    foreach (order[f]) begin
      for (int k = 0; k < NN; k++) begin
        d = (order[f] == 0) ? ref0.pop_front() : ref1.pop_front();
        if (idx < cap_c.size()) check("c_sample", 64'(cap_c[idx]), 64'({addr_of(k), d}));
        idx++;
      end
    end
  endtask

  task automatic check_o();
    logic tg, last;
    check("o_count", 64'(cap_o.size()), 64'(exp_o.size()));
    for (int i = 0; i < cap_o.size() && i < exp_o.size(); i++) begin
      tg   = (i / NN < order.size()) ? (order[i / NN] == 1) : 1'b0;
      last = ((i % NN) == NN - 1);
      check("o_sample", 64'(cap_o[i]), 64'({tg, last, exp_o[i]}));
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_c_en"},   64'(bus.c_en), 0);
    check({pfx, "_c_addr"}, 64'(bus.c_addr), 0);
    check({pfx, "_c_data"}, 64'({bus.c_real, bus.c_imag}), 0);
    check({pfx, "_oen"},    64'(bus.oen), 0);
    check({pfx, "_oaddr"},  64'(bus.oaddr), 0);
    check({pfx, "_odata"},  64'({bus.oReal, bus.oImag}), 0);
    check({pfx, "_ochan"},  64'(bus.ochan), 0);
    check({pfx, "_olast"},  64'(bus.olast), 0);
    check({pfx, "_err"},    64'(bus.err), 0);
    check({pfx, "_ready"},  64'({bus.s0_ready, bus.s1_ready}), 0);
    check({pfx, "_busy"},   64'(bus.busy), 0);
  endtask

  task automatic clear();
    src0.delete(); src1.delete(); ref0.delete(); ref1.delete();
    exp_o.delete(); cap_c.delete(); cap_o.delete(); cap_cyc.delete(); order.delete();
    r_left = 0; rpct = 100; alt0 = 1'b0; hold_chk = 1'b0;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    bus.s0_real = '0; bus.s0_imag = '0; bus.s1_real = '0; bus.s1_imag = '0;
    bus.r_en = 1'b0; bus.r_addr = '0; bus.r_real = '0; bus.r_imag = '0;
  endtask

  task automatic do_reset();
    @(negedge iclk);
    rst_n = 1'b0;
    clear();
    repeat (2) @(negedge iclk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear();
    repeat (3) @(negedge iclk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Single s0 frame, continuous valid, then one result frame.
    load(0, 1); model_order(1, 0);
    run_c(NN, 4 * NN);
    idle(2);
    check("busy_tag_pending", 64'(bus.busy), 1);
    r_left = NN;
    run_o(NN, 4 * NN);
    idle(2);
    check("busy_drop", 64'(bus.busy), 0);
    check("err_clean1", 64'(bus.err), 0);
    check_c(); check_o();

    // Both sources valid from reset: alternating grants with a single bubble.
    do_reset();
    load(0, 2); load(1, 2); model_order(2, 2);
    run_c(4 * NN, 12 * NN);
    if (cap_cyc.size() >= 4 * NN)
      for (int f = 1; f < 4; f++) check("bubble", 64'(cap_cyc[f * NN] - cap_cyc[f * NN - 1]), 2);
    idle(2);
    r_left = 4 * NN; rpct = 60;
    run_o(4 * NN, 20 * NN);
    idle(2);
    check_c(); check_o();
    check("busy_drop_rr", 64'(bus.busy), 0);
    check("err_clean2", 64'(bus.err), 0);

    // s0 valid on alternate cycles: gaps in c_en, address held across them.
    do_reset();
    alt0 = 1'b1; hold_chk = 1'b1;
    load(0, 1); model_order(1, 0);
    run_c(NN, 6 * NN);
    if (cap_cyc.size() >= NN) check("gap_span", 64'(cap_cyc[NN - 1] - cap_cyc[0]), 64'(2 * NN - 2));
    hold_chk = 1'b0;
    r_left = NN; rpct = 50;
    run_o(NN, 8 * NN);
    check_c(); check_o();

    // Core stalled with five frames on offer: only TAG_DEPTH enter until a result frame pops.
    do_reset();
    load(0, 3); load(1, 2); model_order(3, 2);
    idle(6 * NN + 40);
    check("stall_accepted", 64'(cap_c.size()), 64'(4 * NN));
    check("stall_ready", 64'({bus.s0_ready, bus.s1_ready}), 0);
    check("stall_busy", 64'(bus.busy), 1);
    r_left = NN;
    run_c(5 * NN, 4 * NN);
    r_left += 4 * NN;
    run_o(5 * NN, 12 * NN);
    idle(2);
    check_c(); check_o();
    check("busy_drop_stall", 64'(bus.busy), 0);

    // Result with no frame outstanding, then reset in the middle of a frame.
    do_reset();
    r_left = 1;
    idle(3);
    check("err_set", 64'(bus.err), 1);
    check("err_sample_cnt", 64'(cap_o.size()), 1);
    if (cap_o.size() > 0) check("err_chan", 64'(cap_o[0][TS+DW+1]), 0);
    idle(5);
    check("err_sticky", 64'(bus.err), 1);
    load(0, 1);
    run_c(NN / 2, 4 * NN);
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    do_reset();
    idle(3);
    check("midrst_busy", 64'(bus.busy), 0);
    r_left = 1;
    idle(3);
    check("midrst_no_tag", 64'(bus.err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
